// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: owns the fetch PC; applies trap/mret/branch redirects and the IF/ID flush window.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        ex_valid_in,
    input  logic        branch_taken_in,
    input  logic        is_jalr_in,
    input  logic [31:0] ex_pc_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] rs1_in,
    input  logic        trap_in,
    input  logic [31:0] trap_vector_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    output logic [31:0] pc_out,
    output logic        fetch_req_out,
    output logic        flush_out,
    output logic        redirect_out,
    output logic        misaligned_out
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] br_target, target, seq_pc;
    logic        take_trap, take_mret, take_br, redir, misal;

    // EX-sourced redirects are only trusted in RUN; in FLUSH the EX slot holds killed work.
    always_comb begin
        br_target = is_jalr_in ? (rs1_in + imm_in) & ~32'h1 : ex_pc_in + imm_in;
        take_trap = trap_in && state != BOOT;
        take_mret = state == RUN && mret_in && ex_valid_in;
        take_br   = state == RUN && branch_taken_in && ex_valid_in && !take_mret;
        target    = take_trap ? trap_vector_in : take_mret ? epc_in : br_target;
        misal     = !take_trap && (take_mret || take_br) && target[1];
        redir     = take_trap || ((take_mret || take_br) && !target[1]);
        seq_pc    = stall_in ? pc_out : pc_out + 32'd4;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= BOOT;
            pc_out         <= RESET_VECTOR;
            fetch_req_out  <= 1'b0;
            flush_out      <= 1'b0;
            redirect_out   <= 1'b0;
            misaligned_out <= 1'b0;
            cnt            <= 3'd0;
        end else begin
            redirect_out   <= redir;
            misaligned_out <= misal;
            if (state == BOOT) begin
                state         <= RUN;
                fetch_req_out <= 1'b1;
            end else if (redir) begin
                pc_out    <= target;
                state     <= FLUSH;
                flush_out <= 1'b1;
                cnt       <= CNT_LOAD;
            end else begin
                pc_out <= seq_pc;
                if (state == FLUSH && !stall_in) begin
                    if (cnt == 3'd0) begin
                        state     <= RUN;
                        flush_out <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed vectors checked against a behavioural next-PC model plus literal pins.
module tb_pc_redirect_ctrl;
    localparam logic [31:0] RV = 32'h100;
    localparam int          FC = 2;

    logic        clk = 0, rst = 1;
    logic        stall = 0, ex_valid = 0, br = 0, jalr = 0, trap = 0, mret = 0;
    logic [31:0] ex_pc = 0, imm = 0, rs1 = 0, tvec = 0, epc = 0;
    logic [31:0] pc;
    logic        fetch, flush, redir, misal;

    pc_redirect_ctrl #(.RESET_VECTOR(RV), .FLUSH_CYCLES(FC)) dut (
        .clk_in(clk), .rst_in(rst), .stall_in(stall), .ex_valid_in(ex_valid),
        .branch_taken_in(br), .is_jalr_in(jalr), .ex_pc_in(ex_pc), .imm_in(imm),
        .rs1_in(rs1), .trap_in(trap), .trap_vector_in(tvec), .mret_in(mret),
        .epc_in(epc), .pc_out(pc), .fetch_req_out(fetch), .flush_out(flush),
        .redirect_out(redir), .misaligned_out(misal)
    );

    always #5 clk = ~clk;

    // Model: flush_left counts the non-stalled flush cycles still owed.
    logic [31:0] m_pc;
    int          m_left;
    logic        m_booted, m_redir, m_mis;

    function automatic logic [31:0] cf_target();
        return mret ? epc : jalr ? (rs1 + imm) & 32'hFFFF_FFFE : ex_pc + imm;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_booted <= 0; m_pc <= RV; m_left <= 0; m_redir <= 0; m_mis <= 0;
        end else if (!m_booted) begin
            m_booted <= 1; m_redir <= 0; m_mis <= 0;
        end else if (trap) begin
            m_pc <= tvec; m_left <= FC; m_redir <= 1; m_mis <= 0;
        end else if (m_left == 0 && ex_valid && (mret || br) && (cf_target() & 32'h2) == 0) begin
            m_pc <= cf_target(); m_left <= FC; m_redir <= 1; m_mis <= 0;
        end else begin
            m_redir <= 0;
            m_mis   <= m_left == 0 && ex_valid && (mret || br);
            m_pc    <= stall ? m_pc : m_pc + 32'd4;
            if (m_left > 0 && !stall) m_left <= m_left - 1;
        end
    end

    int          checks = 0, errors = 0;
    logic        lit_on = 0;
    logic [31:0] l_pc;
    logic        l_fetch, l_flush, l_redir, l_misal;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", n, $time, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_pc", pc, RV);
            chk("rst_flags", {fetch, flush, redir, misal}, 0);
        end else begin
            chk("pc", pc, m_pc);
            chk("fetch", fetch, m_booted);
            chk("flush", flush, m_left > 0);
            chk("redirect", redir, m_redir);
            chk("misaligned", misal, m_mis);
        end
        if (lit_on) begin
            chk("lit_pc", pc, l_pc);
            chk("lit_flags", {fetch, flush, redir, misal}, {l_fetch, l_flush, l_redir, l_misal});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1 lit_on = 0;
    endtask

    task automatic expect_out(input logic [31:0] p, input logic f, fl, rd, ms);
        l_pc = p; l_fetch = f; l_flush = fl; l_redir = rd; l_misal = ms; lit_on = 1;
    endtask

    task automatic clear_in();
        stall = 0; ex_valid = 0; br = 0; jalr = 0; trap = 0; mret = 0;
    endtask

    task automatic branch(input logic j, input logic [31:0] pc_v, r, i);
        ex_valid = 1; br = 1; jalr = j; ex_pc = pc_v; rs1 = r; imm = i;
    endtask

    initial begin
        tick(); tick();
        rst = 0;
        expect_out(32'h100, 0, 0, 0, 0);
        tick(); expect_out(32'h100, 1, 0, 0, 0);
        tick(); expect_out(32'h104, 1, 0, 0, 0);
        tick(); expect_out(32'h108, 1, 0, 0, 0);
        branch(0, 32'h200, 0, 32'h40);
        tick(); expect_out(32'h240, 1, 1, 1, 0); clear_in();
        tick(); expect_out(32'h244, 1, 1, 0, 0);
        tick(); expect_out(32'h248, 1, 0, 0, 0);
        branch(1, 0, 32'h1001, 32'h3);
        tick(); expect_out(32'h1004, 1, 1, 1, 0); clear_in();
        tick(); tick(); expect_out(32'h100C, 1, 0, 0, 0);
        branch(1, 0, 32'h1000, 32'h2);
        tick(); expect_out(32'h1010, 1, 0, 0, 1); clear_in();
        tick(); expect_out(32'h1014, 1, 0, 0, 0);
        ex_valid = 1; mret = 1; epc = 32'h500;
        tick(); expect_out(32'h500, 1, 1, 1, 0); clear_in();
        tick(); tick(); expect_out(32'h508, 1, 0, 0, 0);
        trap = 1; tvec = 32'h80; branch(0, 32'h200, 0, 32'h40);
        tick(); expect_out(32'h80, 1, 1, 1, 0); clear_in();
        tick(); expect_out(32'h84, 1, 1, 0, 0);
        trap = 1; tvec = 32'h90;
        tick(); expect_out(32'h90, 1, 1, 1, 0); clear_in();
        tick(); expect_out(32'h94, 1, 1, 0, 0);
        tick(); expect_out(32'h98, 1, 0, 0, 0);
        branch(0, 32'h2F0, 0, 32'h8);
        tick(); expect_out(32'h2F8, 1, 1, 1, 0); clear_in();
        branch(0, 32'h1000, 0, 32'h0);
        tick(); expect_out(32'h2FC, 1, 1, 0, 0); clear_in();
        tick(); expect_out(32'h300, 1, 0, 0, 0);
        stall = 1;
        repeat (3) begin tick(); expect_out(32'h300, 1, 0, 0, 0); end
        branch(0, 32'h400, 0, 32'h10);
        tick(); expect_out(32'h410, 1, 1, 1, 0); ex_valid = 0; br = 0;
        repeat (3) begin tick(); expect_out(32'h410, 1, 1, 0, 0); end
        stall = 0;
        tick(); expect_out(32'h414, 1, 1, 0, 0);
        tick(); expect_out(32'h418, 1, 0, 0, 0);
        trap = 1; tvec = 32'hFFFF_FFF8;
        tick(); clear_in();
        tick(); expect_out(32'hFFFF_FFFC, 1, 1, 0, 0);
        tick(); expect_out(32'h0000_0000, 1, 0, 0, 0);
        tick(); expect_out(32'h0000_0004, 1, 0, 0, 0);
        trap = 1; tvec = 32'h700;
        tick(); expect_out(32'h700, 1, 1, 1, 0); clear_in();
        @(negedge clk);
        @(posedge clk); #1 rst = 1;
        expect_out(32'h100, 0, 0, 0, 0);
        @(negedge clk); #1 rst = 0;
        tick(); expect_out(32'h100, 1, 0, 0, 0);
        tick(); expect_out(32'h104, 1, 0, 0, 0);
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Next-PC sequencer for the RV32 pipeline. It owns the architectural fetch PC register and consumes the branch/jump resolution from the EX-stage branch unit (branch_taken) plus trap and mret requests. It issues the fetch request, the redirect and the younger-stage flush. It sits between the EX stage and instruction fetch and performs all control-flow changes.

Parameters:
RESET_VECTOR  32'h0000_0000  PC loaded on reset
FLUSH_CYCLES  2  cycles flush_out stays high after a redirect (IF+ID kill); legal range 1..7

Ports:
clk_in  input  1  core clock, all state on rising edge
rst_in  input  1  asynchronous, active-high reset
stall_in  input  1  pipeline stall; freezes sequential PC advance and flush counter
ex_valid_in  input  1  EX-stage instruction valid (not killed)
branch_taken_in  input  1  from branch unit: branch taken or JAL/JALR
is_jalr_in  input  1  EX instruction is JALR
ex_pc_in  input  32  PC of EX instruction
imm_in  input  32  sign-extended immediate of EX instruction
rs1_in  input  32  rs1 operand of EX instruction
trap_in  input  1  take trap this cycle
trap_vector_in  input  32  trap handler address (mtvec)
mret_in  input  1  EX instruction is MRET
epc_in  input  32  mepc return address
pc_out  output  32  current fetch PC
fetch_req_out  output  1  fetch at pc_out this cycle
flush_out  output  1  kill IF/ID contents
redirect_out  output  1  one-cycle pulse: pc_out changed non-sequentially last edge
misaligned_out  output  1  one-cycle pulse: taken target not 4-byte aligned

Behaviour:
- Reset (async, while rst_in=1): state=BOOT, pc_out=RESET_VECTOR, fetch_req_out=0, flush_out=0, redirect_out=0, misaligned_out=0, flush counter=0.
- States:
  - BOOT: on the first edge after reset deassert, go to RUN and set fetch_req_out=1. pc_out is unchanged. Inputs are ignored.
  - RUN: fetch_req_out=1. Evaluate the redirect priority each edge.
  - FLUSH: fetch_req_out=1, flush_out=1. The counter is loaded with FLUSH_CYCLES-1 on entry and decrements each non-stalled edge. At 0 with no stall, go to RUN and clear flush_out.
- Redirect priority, highest first:
  1. trap_in: target = trap_vector_in. Accepted in RUN and FLUSH.
  2. mret_in & ex_valid_in: target = epc_in. RUN only.
  3. branch_taken_in & ex_valid_in: target = ex_pc_in+imm_in, or (rs1_in+imm_in) & ~32'h1 when is_jalr_in. RUN only.
  4. Otherwise, sequential: pc_out <= pc_out+4 when !stall_in, else hold.
- Redirects override stall_in.
- Branch and mret redirects arriving in FLUSH are ignored, because EX holds killed instructions. A trap in FLUSH reloads the target and restarts the counter.
- Redirect accepted at edge N:
  - pc_out=target after N.
  - redirect_out=1 for the cycle after N only.
  - flush_out=1 from after N for exactly FLUSH_CYCLES non-stalled cycles; stall cycles extend it.
  - Next state FLUSH.
- Misalignment: if a branch/jal/jalr/mret target has bit[1]=1, do not redirect. Pulse misaligned_out for one cycle and continue sequentially; upstream raises trap_in. Trap targets are never checked.
- Arithmetic: all adds are 32-bit modulo 2^32. pc_out+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- Reset asserted mid-FLUSH aborts immediately to reset values.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset release with RESET_VECTOR=32'h100: cycle 1 pc_out=0x100, fetch_req_out=0; next edge fetch_req_out=1; following edges pc_out=0x104, 0x108.
- BEQ taken, ex_pc_in=0x200, imm_in=0x40 -> pc_out=0x240, redirect_out pulse for 1 cycle, flush_out high exactly 2 cycles, then pc_out=0x244.
- JALR with rs1_in=0x1001, imm_in=0x3 -> pc_out=0x1004. JALR with rs1_in=0x1000, imm_in=0x2 -> misaligned_out pulse, no flush, sequential PC.
- trap_in and branch_taken_in on the same edge (trap_vector_in=0x80) -> pc_out=0x80. Second trap during FLUSH to 0x90 -> pc_out=0x90, flush_out extended by a full 2 cycles.
- stall_in high 3 cycles in RUN at pc_out=0x300 -> pc_out holds 0x300. Branch while stalled still redirects. Stall during FLUSH extends flush_out by 3 cycles.
- pc_out=0xFFFF_FFFC with no redirect -> wraps to 0x0000_0000. rst_in asserted mid-FLUSH -> all outputs return to reset values asynchronously.
